// File: rtl/cnu_row_sched_if.sv
// Result-record stream from the check-node row scheduler to the check-to-variable update stage.
// One record per parity-check row: row/iteration tag, min, min2, one-hot min index, sign parity.
// valid/ready handshake: the record is held stable while valid=1 and ready=0.
interface cnu_row_sched_if #(
    parameter int ROW_W  = 6,
    parameter int ITER_W = 4,
    parameter int D      = 7,
    parameter int data_w = 9
);
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row;
    logic [ITER_W-1:0] out_iter;
    logic [data_w-1:0] out_min;
    logic [data_w-1:0] out_min2;
    logic [D-1:0]      out_idx;
    logic              out_sign;

    modport master (
        output out_valid, out_row, out_iter, out_min, out_min2, out_idx, out_sign,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_iter, out_min, out_min2, out_idx, out_sign,
        output out_ready
    );
endinterface

// File: rtl/cnu_row_sched.sv
// Sequences LDPC check-node rows: read row, pulse min-finder, capture min/min2/idx/sign, emit record.
// Latency rd_en -> out_valid is 3 cycles; 4 cycles per row with out_ready high; one row in flight.
// Stalls in HOLD while out_ready=0. Optional early stop on satisfied parity: CNU_ROW_SCHED_EARLY_STOP_EN.
module cnu_row_sched #(
    parameter int ROWS   = 64,
    parameter int ROW_W  = 6,
    parameter int ITER_W = 4,
    parameter int D      = 7,
    parameter int data_w = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iters,
    output logic              busy,
    output logic              done,
    output logic              stopped,
    output logic              rd_en,
    output logic [ROW_W-1:0]  rd_addr,
    input  logic [D-1:0]      sign_in,
    output logic              cmp_en,
    input  logic [data_w-1:0] cmp_min,
    input  logic [data_w-1:0] cmp_min2,
    input  logic [D-1:0]      cmp_idx,
    cnu_row_sched_if.master   out_if
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, READ, CMP, CAPT, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  row;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iters_m1;   // latched iteration count minus one (0 treated as 1)
    logic              sign_pend;  // row parity captured while the finder evaluates
    logic              accept;
    logic              last_row;
    logic              last_iter;
    logic              early;
    logic              finish;

    assign accept    = (state == HOLD) && out_if.out_ready;
    assign last_row  = (row == LAST_ROW);
    assign last_iter = (iter == iters_m1);
    assign finish    = accept && ((last_row && last_iter) || early);

    assign rd_en   = (state == READ);
    assign rd_addr = row;
    assign cmp_en  = (state == CMP);

`ifdef CNU_ROW_SCHED_EARLY_STOP_EN
    logic par_flag;  // OR of accepted record signs in the current iteration
    logic par_now;

    assign par_now = par_flag | out_if.out_sign;
    assign early   = accept && last_row && !par_now;

    // Track per-iteration parity; flag a satisfied code word as an early stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_flag <= 1'b0;
            stopped  <= 1'b0;
        end else if (state == IDLE && start) begin
            par_flag <= 1'b0;
            stopped  <= 1'b0;
        end else if (accept) begin
            if (last_row) begin
                par_flag <= 1'b0;
                if (!par_now) stopped <= 1'b1;
            end else begin
                par_flag <= par_now;
            end
        end
    end
`else
    assign early   = 1'b0;
    assign stopped = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: fixed READ->CMP->CAPT->HOLD walk, HOLD waits for acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = CMP;
            CMP:     state_nxt = CAPT;
            CAPT:    state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = finish ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, status flags and the output record registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            row              <= '0;
            iter             <= '0;
            iters_m1         <= '0;
            sign_pend        <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_row   <= '0;
            out_if.out_iter  <= '0;
            out_if.out_min   <= '0;
            out_if.out_min2  <= '0;
            out_if.out_idx   <= '0;
            out_if.out_sign  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        iters_m1 <= (iters == '0) ? '0 : iters - ITER_W'(1);
                        row      <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                    end
                end
                CMP: begin
                    sign_pend <= ^sign_in;
                end
                CAPT: begin
                    out_if.out_valid <= 1'b1;
                    out_if.out_row   <= row;
                    out_if.out_iter  <= iter;
                    out_if.out_min   <= cmp_min;
                    out_if.out_min2  <= cmp_min2;
                    out_if.out_idx   <= cmp_idx;
                    out_if.out_sign  <= sign_pend;
                end
                HOLD: begin
                    if (accept) begin
                        out_if.out_valid <= 1'b0;
                        if (finish) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            row  <= '0;
                            iter <= '0;
                        end else if (last_row) begin
                            row  <= '0;
                            iter <= iter + ITER_W'(1);
                        end else begin
                            row  <= row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnu_row_sched.sv
// Directed bench for cnu_row_sched with ROWS=4; min-finder and message memory modelled by tables.
module tb_cnu_row_sched;

    localparam int ROWS   = 4;
    localparam int ROW_W  = 2;
    localparam int ITER_W = 4;
    localparam int D      = 7;
    localparam int DW     = 9;

    // Per-row memory/finder data and hand-computed expected record signs.
    localparam logic [6:0]    SIGN_TAB [4] = '{7'b1011001, 7'b0000001, 7'b1110000, 7'b0101010};
    localparam logic          EXP_SIGN [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [DW-1:0] MIN_TAB  [4] = '{9'd3, 9'd7, 9'd1, 9'd511};
    localparam logic [DW-1:0] MIN2_TAB [4] = '{9'd5, 9'd9, 9'd1, 9'd511};
    localparam logic [6:0]    IDX_TAB  [4] = '{7'b0000100, 7'b0000001, 7'b1000000, 7'b0010000};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] iters = '0;
    logic              busy, done, stopped, rd_en, cmp_en;
    logic [ROW_W-1:0]  rd_addr;
    logic [D-1:0]      sign_in;
    logic [DW-1:0]     cmp_min, cmp_min2;
    logic [D-1:0]      cmp_idx;

    logic              clr_cnt = 1'b0;
    logic              es_mode = 1'b0;
    int                rd_num = 0;
    int                rd_iter_q = 0;
    logic [1:0]        rd_row_q = '0;

    int tests = 0;
    int fails = 0;

    cnu_row_sched_if #(.ROW_W(ROW_W), .ITER_W(ITER_W), .D(D), .data_w(DW)) oif ();

    cnu_row_sched #(.ROWS(ROWS), .ROW_W(ROW_W), .ITER_W(ITER_W), .D(D), .data_w(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .iters(iters),
        .busy(busy), .done(done), .stopped(stopped),
        .rd_en(rd_en), .rd_addr(rd_addr), .sign_in(sign_in),
        .cmp_en(cmp_en), .cmp_min(cmp_min), .cmp_min2(cmp_min2), .cmp_idx(cmp_idx),
        .out_if(oif)
    );

    always #5 clk = ~clk;

    // Memory model: remember which row (and which decode iteration) was last read.
    always @(posedge clk) begin
        if (clr_cnt) begin
            rd_num <= 0;
        end else if (rd_en) begin
            rd_row_q  <= rd_addr;
            rd_iter_q <= rd_num / ROWS;
            rd_num    <= rd_num + 1;
        end
    end

    // In early-stop mode, iteration 1 reads all-even sign words.
    assign sign_in  = (es_mode && rd_iter_q == 1) ? 7'b0000011 : SIGN_TAB[rd_row_q];
    assign cmp_min  = MIN_TAB[rd_row_q];
    assign cmp_min2 = MIN2_TAB[rd_row_q];
    assign cmp_idx  = IDX_TAB[rd_row_q];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        iters = ITER_W'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_busy: busy=%b done=%b want 1/0", busy, done);
        end
    endtask

    // Walk one row from its READ cycle to acceptance, with an optional HOLD stall.
    task automatic do_row(input int r, input int it, input int stall, input bit even);
        logic exp_s;
        logic [ROW_W+ITER_W+2*DW+D:0] want;
        exp_s = even ? 1'b0 : EXP_SIGN[r];
        want  = {ROW_W'(r), ITER_W'(it), MIN_TAB[r], MIN2_TAB[r], IDX_TAB[r], exp_s};
        tests++;
        if (rd_en !== 1'b1 || rd_addr !== ROW_W'(r) || cmp_en !== 1'b0) begin
            fails++;
            $display("FAIL read r%0d i%0d: rd_en=%b rd_addr=%0d cmp_en=%b want 1/%0d/0",
                     r, it, rd_en, rd_addr, cmp_en, r);
        end
        tick;
        tests++;
        if (cmp_en !== 1'b1 || rd_en !== 1'b0 || oif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL cmp r%0d i%0d: cmp_en=%b rd_en=%b out_valid=%b want 1/0/0",
                     r, it, cmp_en, rd_en, oif.out_valid);
        end
        tick;
        tests++;
        if (cmp_en !== 1'b0 || oif.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL capt r%0d i%0d: cmp_en=%b out_valid=%b want 0/0",
                     r, it, cmp_en, oif.out_valid);
        end
        oif.out_ready = (stall == 0);
        tick;
        tests++;
        if (oif.out_valid !== 1'b1 ||
            {oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx, oif.out_sign} !== want) begin
            fails++;
            $display("FAIL record r%0d i%0d: valid=%b rec=%h want 1/%h", r, it, oif.out_valid,
                     {oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx, oif.out_sign}, want);
        end
        for (int k = 0; k < stall; k++) begin
            tick;
            tests++;
            if (oif.out_valid !== 1'b1 || rd_en !== 1'b0 ||
                {oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx, oif.out_sign} !== want) begin
                fails++;
                $display("FAIL hold r%0d k%0d: valid=%b rd_en=%b rec=%h want 1/0/%h", r, k, oif.out_valid,
                         rd_en, {oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx, oif.out_sign}, want);
            end
        end
        oif.out_ready = 1'b1;
        tick;
    endtask

    task automatic check_done(input string name, input logic exp_stop);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || oif.out_valid !== 1'b0 || stopped !== exp_stop) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b valid=%b stopped=%b want 1/0/0/%b",
                     name, done, busy, oif.out_valid, stopped, exp_stop);
        end
        tick;
        tests++;
        if (done !== 1'b0 || rd_en !== 1'b0 || stopped !== exp_stop) begin
            fails++;
            $display("FAIL %s_idle: done=%b rd_en=%b stopped=%b want 0/0/%b", name, done, rd_en, stopped, exp_stop);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        oif.out_ready = 1'b1;
        tick;
        tick;
        tests++;
        if ({busy, done, stopped, rd_en, cmp_en, oif.out_valid, oif.out_sign} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, done, stopped, rd_en, cmp_en, oif.out_valid, oif.out_sign});
        end
        tests++;
        if ({rd_addr, oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got %h want 0",
                     {rd_addr, oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx});
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_iter;
        do_start(1);
        for (int r = 0; r < ROWS; r++) do_row(r, 0, 0, 1'b0);
        check_done("single", 1'b0);
    endtask

    task automatic test_stall;
        do_start(1);
        do_row(0, 0, 0, 1'b0);
        // A start pulse with a different count while busy must change nothing.
        start = 1'b1;
        iters = 4'd7;
        do_row(1, 0, 5, 1'b0);
        start = 1'b0;
        do_row(2, 0, 0, 1'b0);
        do_row(3, 0, 0, 1'b0);
        check_done("stall", 1'b0);
    endtask

    task automatic test_iters_zero;
        do_start(0);
        for (int r = 0; r < ROWS; r++) do_row(r, 0, 0, 1'b0);
        check_done("iters0", 1'b0);
    endtask

    task automatic test_iters_three;
        do_start(3);
        for (int it = 0; it < 3; it++)
            for (int r = 0; r < ROWS; r++) do_row(r, it, 0, 1'b0);
        check_done("iters3", 1'b0);
    endtask

    task automatic test_rst_mid;
        do_start(2);
        for (int r = 0; r < ROWS; r++) do_row(r, 0, 0, 1'b0);
        do_row(0, 1, 0, 1'b0);
        do_row(1, 1, 0, 1'b0);
        tick;
        tests++;
        if (cmp_en !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_cmp: cmp_en=%b want 1", cmp_en);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++;
        if ({busy, done, stopped, rd_en, cmp_en, oif.out_valid, oif.out_sign} !== 7'b0 ||
            {rd_addr, oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx} !== '0) begin
            fails++;
            $display("FAIL rst_mid_clear: flags=%b bus=%h want 0/0",
                     {busy, done, stopped, rd_en, cmp_en, oif.out_valid, oif.out_sign},
                     {rd_addr, oif.out_row, oif.out_iter, oif.out_min, oif.out_min2, oif.out_idx});
        end
        tick;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_quiet: done=%b busy=%b rd_en=%b want 0/0/0", done, busy, rd_en);
        end
        do_start(1);
        for (int r = 0; r < ROWS; r++) do_row(r, 0, 0, 1'b0);
        check_done("rst_fresh", 1'b0);
    endtask

    task automatic test_early_stop;
        es_mode = 1'b1;
        do_start(5);
        for (int r = 0; r < ROWS; r++) do_row(r, 0, 0, 1'b0);
        for (int r = 0; r < ROWS; r++) do_row(r, 1, 0, 1'b1);
`ifdef CNU_ROW_SCHED_EARLY_STOP_EN
        check_done("early", 1'b1);
`else
        for (int it = 2; it < 5; it++)
            for (int r = 0; r < ROWS; r++) do_row(r, it, 0, 1'b0);
        check_done("early", 1'b0);
`endif
        es_mode = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_iter;
        test_stall;
        test_iters_zero;
        test_iters_three;
        test_rst_mid;
        test_early_stop;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
